// File: rtl/lfsr_checker.sv
// lfsr_checker -- receive-side checker for the 4-bit PRBS stream of the LFSR
// generator (next(x) = {x[2:0], x[3]^x[2]}, period 15, zero state illegal).
// Self-synchronises to the incoming samples. Once locked, it predicts the
// sequence from its own state and counts mismatches.
//
// Optional feature macro: LFSR_CHECKER_STATS_EN adds sample_count_o.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   valid_i        data_i carries a sample this cycle
//   data_i[3:0]    received LFSR value
//   clr_i          synchronous clear of the statistics counters
//   locked_o       checker is in LOCKED
//   err_pulse_o    one-cycle pulse per mismatch while locked
//   err_count_o    saturating mismatch count
//   sample_count_o (LFSR_CHECKER_STATS_EN) saturating count of locked samples
module lfsr_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [3:0]       data_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_pulse_o,
`ifdef LFSR_CHECKER_STATS_EN
  output logic [ERR_W-1:0] sample_count_o,
`endif
  output logic [ERR_W-1:0] err_count_o
);

  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int LW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;
  localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0]    LOSS_LAST = LW'(LOSS_COUNT - 1);
  localparam logic [ERR_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

  function automatic logic [3:0] lfsr_next(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[2]};
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       expect_q, expect_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             pulse_q, pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_hit;

  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    match_d  = match_q;
    miss_d   = miss_q;
    err_hit  = 1'b0;
    if (valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (data_i != 4'd0) begin
            expect_d = lfsr_next(data_i);
            match_d  = '0;
            state_d  = VERIFY;
          end
        end
        VERIFY: begin
          if (data_i == expect_q) begin
            expect_d = lfsr_next(data_i);
            if (match_q == LOCK_LAST) begin
              match_d = '0;
              miss_d  = '0;
              state_d = LOCKED;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else if (data_i != 4'd0) begin
            // Reseed from the received value rather than restarting the hunt.
            expect_d = lfsr_next(data_i);
            match_d  = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: prediction advances on its own; bad data never reseeds.
          expect_d = lfsr_next(expect_q);
          if (data_i == expect_q) begin
            miss_d = '0;
          end else begin
            err_hit = 1'b1;
            if (miss_q == LOSS_LAST) begin
              miss_d  = '0;
              state_d = HUNT;
            end else begin
              miss_d = miss_q + LW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_hit && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
    // Clear takes priority over a coincident increment.
    if (clr_i) err_cnt_d = '0;
    pulse_d  = err_hit;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= HUNT;
      expect_q  <= 4'd0;
      match_q   <= '0;
      miss_q    <= '0;
      locked_q  <= 1'b0;
      pulse_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      expect_q  <= expect_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked_q  <= locked_d;
      pulse_q   <= pulse_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked_o    = locked_q;
  assign err_pulse_o = pulse_q;
  assign err_count_o = err_cnt_q;

`ifdef LFSR_CHECKER_STATS_EN
  logic [ERR_W-1:0] samp_q, samp_d;

  always_comb begin
    samp_d = samp_q;
    if (valid_i && state_q == LOCKED && samp_q != CNT_MAX) samp_d = samp_q + ERR_W'(1);
    if (clr_i) samp_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) samp_q <= '0;
    else         samp_q <= samp_d;
  end

  assign sample_count_o = samp_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: table-driven directed vectors, hand-written corner
// sequences and a randomized stream checked against a sequence-position model.
// Two instances share the stimulus: default widths, and ERR_W=2 for saturation.
module tb_lfsr_checker;
  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] data = 4'd0;
  logic       clr = 1'b0;
  logic       locked, pulse, locked2, pulse2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
`ifdef LFSR_CHECKER_STATS_EN
  logic [7:0] samp;
  logic [1:0] samp2;
`endif

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  lfsr_checker #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clr_i(clr),
    .locked_o(locked), .err_pulse_o(pulse),
`ifdef LFSR_CHECKER_STATS_EN
    .sample_count_o(samp),
`endif
    .err_count_o(cnt));

  lfsr_checker #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_W(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clr_i(clr),
    .locked_o(locked2), .err_pulse_o(pulse2),
`ifdef LFSR_CHECKER_STATS_EN
    .sample_count_o(samp2),
`endif
    .err_count_o(cnt2));

  int tests = 0;
  int fails = 0;

  // Sequence table: seq[i] is the i-th state from 0001; pos_of inverts it.
  int seq[15];
  int pos_of[16];

  // Model: mode 0=hunt 1=verify 2=locked; m_pos indexes the expected value.
  int m_mode, m_pos, m_run, m_miss, m_cnt, m_cnt2, m_samp, m_samp2;
  bit m_pulse;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_run = 0; m_miss = 0;
    m_cnt = 0; m_cnt2 = 0; m_samp = 0; m_samp2 = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    m_pulse = 0;
    if (v) begin
      case (m_mode)
        0: if (d != 0) begin m_pos = (pos_of[d] + 1) % 15; m_run = 0; m_mode = 1; end
        1: begin
          if (d == seq[m_pos]) begin
            m_pos = (m_pos + 1) % 15;
            m_run++;
            if (m_run == LOCK) begin m_mode = 2; m_miss = 0; end
          end else if (d != 0) begin
            m_pos = (pos_of[d] + 1) % 15; m_run = 0;
          end else m_mode = 0;
        end
        default: begin
          if (m_samp < 255) m_samp++;
          if (m_samp2 < 3) m_samp2++;
          if (d == seq[m_pos]) m_miss = 0;
          else begin
            m_pulse = 1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
            m_miss++;
            if (m_miss == LOSS) m_mode = 0;
          end
          m_pos = (m_pos + 1) % 15;
        end
      endcase
    end
    if (c) begin m_cnt = 0; m_cnt2 = 0; m_samp = 0; m_samp2 = 0; end
  endtask

  task automatic check_model();
    chk("locked", int'(locked), int'(m_mode == 2));
    chk("pulse", int'(pulse), int'(m_pulse));
    chk("err_count", int'(cnt), m_cnt);
    chk("locked_w2", int'(locked2), int'(m_mode == 2));
    chk("err_count_w2", int'(cnt2), m_cnt2);
`ifdef LFSR_CHECKER_STATS_EN
    chk("sample_count", int'(samp), m_samp);
    chk("sample_count_w2", int'(samp2), m_samp2);
`endif
  endtask

  // One clock: drive, clock in, advance model, sample #1 after the edge.
  task automatic cyc(input bit v, input int d, input bit c);
    valid = v; data = 4'(d); clr = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    valid = 0; clr = 0; data = 4'd0;
    rst_n = 0;
    model_reset();
    #12;
    chk("rst_locked", int'(locked), 0);
    chk("rst_pulse", int'(pulse), 0);
    chk("rst_count", int'(cnt), 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    bit v; int d; bit c;
    bit el; bit ep; int ec;
  } vec_t;

  vec_t tv1[18];
  vec_t tv2[8];

  initial begin
    seq[0] = 1;
    for (int i = 0; i < 14; i++)
      seq[i+1] = ((seq[i] << 1) & 15) | (((seq[i] >> 3) ^ (seq[i] >> 2)) & 1);
    pos_of[0] = 0;
    for (int i = 0; i < 15; i++) pos_of[seq[i]] = i;

    // Lock, flywheel error, idle cycle, loss of lock, relock.
    tv1[0]  = '{1, 4'b1010, 0, 0, 0, 0};
    tv1[1]  = '{1, 4'b0101, 0, 0, 0, 0};
    tv1[2]  = '{1, 4'b1011, 0, 0, 0, 0};
    tv1[3]  = '{1, 4'b0111, 0, 0, 0, 0};
    tv1[4]  = '{1, 4'b1111, 0, 1, 0, 0};
    tv1[5]  = '{1, 4'b0000, 0, 1, 1, 1};
    tv1[6]  = '{1, 4'b1100, 0, 1, 0, 1};
    tv1[7]  = '{1, 4'b1000, 0, 1, 0, 1};
    tv1[8]  = '{0, 4'b0000, 0, 1, 0, 1};
    tv1[9]  = '{1, 4'b0001, 0, 1, 0, 1};
    tv1[10] = '{1, 4'b0000, 0, 1, 1, 2};
    tv1[11] = '{1, 4'b0000, 0, 1, 1, 3};
    tv1[12] = '{1, 4'b0000, 0, 0, 1, 4};
    tv1[13] = '{1, 4'b0010, 0, 0, 0, 4};
    tv1[14] = '{1, 4'b0100, 0, 0, 0, 4};
    tv1[15] = '{1, 4'b1001, 0, 0, 0, 4};
    tv1[16] = '{1, 4'b0011, 0, 0, 0, 4};
    tv1[17] = '{1, 4'b0110, 0, 1, 0, 4};
    // Hunt through zeros, reseed on a mismatch, lock on 1110.
    tv2[0] = '{1, 4'b0000, 0, 0, 0, 0};
    tv2[1] = '{1, 4'b0000, 0, 0, 0, 0};
    tv2[2] = '{1, 4'b0110, 0, 0, 0, 0};
    tv2[3] = '{1, 4'b0101, 0, 0, 0, 0};
    tv2[4] = '{1, 4'b1011, 0, 0, 0, 0};
    tv2[5] = '{1, 4'b0111, 0, 0, 0, 0};
    tv2[6] = '{1, 4'b1111, 0, 0, 0, 0};
    tv2[7] = '{1, 4'b1110, 0, 1, 0, 0};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      cyc(tv1[i].v, tv1[i].d, tv1[i].c);
      chk($sformatf("tv1[%0d].locked", i), int'(locked), int'(tv1[i].el));
      chk($sformatf("tv1[%0d].pulse", i), int'(pulse), int'(tv1[i].ep));
      chk($sformatf("tv1[%0d].count", i), int'(cnt), tv1[i].ec);
    end

    // Async reset while locked with the clock stopped.
    clk_run = 0;
    #3;
    rst_n = 0;
    #1;
    chk("async_rst_locked", int'(locked), 0);
    chk("async_rst_count", int'(cnt), 0);
    chk("async_rst_pulse", int'(pulse), 0);
    model_reset();
    #3;
    rst_n = 1;
    clk_run = 1;

    for (int i = 0; i < 8; i++) begin
      cyc(tv2[i].v, tv2[i].d, tv2[i].c);
      chk($sformatf("tv2[%0d].locked", i), int'(locked), int'(tv2[i].el));
      chk($sformatf("tv2[%0d].count", i), int'(cnt), tv2[i].ec);
    end

    // Saturation: five errors alternating with good samples, then clear+error.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, seq[i], 0);
    for (int e = 0; e < 5; e++) begin
      cyc(1, 0, 0);
      chk("sat_err_pulse", int'(pulse), 1);
      cyc(1, seq[(6 + 2*e) % 15], 0);
      chk("sat_good_pulse", int'(pulse), 0);
    end
    chk("sat_count_w2", int'(cnt2), 3);
    chk("sat_count_w8", int'(cnt), 5);
    chk("sat_locked", int'(locked), 1);
    cyc(1, 0, 1);
    chk("clr_err_count", int'(cnt), 0);
    chk("clr_err_count_w2", int'(cnt2), 0);
    chk("clr_err_pulse", int'(pulse), 1);

    // Ten samples accepted while locked.
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1, seq[i], 0);
`ifdef LFSR_CHECKER_STATS_EN
    chk("stats_10", int'(samp), 10);
    chk("stats_10_w2", int'(samp2), 3);
`endif
    chk("stats_locked", int'(locked), 1);

    // Randomized stream: mostly correct, with corruption, zeros, jumps, clears.
    do_reset();
    begin
      int idx = 0;
      for (int n = 0; n < 3000; n++) begin
        bit v = ($urandom_range(0, 3) != 0);
        bit c = ($urandom_range(0, 63) == 0);
        int d = $urandom_range(0, 15);
        if (v) begin
          int r = $urandom_range(0, 99);
          if (r < 6) d = $urandom_range(0, 15);
          else if (r < 9) d = 0;
          else if (r < 11) begin idx = $urandom_range(0, 14); d = seq[idx]; end
          else d = seq[idx];
          idx = (idx + 1) % 15;
        end
        cyc(v, d, c);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side checker for the 4-bit PRBS stream produced by the team's LFSR generator (feedback `next(x) = {x[2:0], x[3]^x[2]}`, period 15, all-zero state illegal). It samples the generator's output through a valid strobe, self-synchronises to the sequence, then flywheels its own prediction and counts mismatches. It sits at the far end of a test/data path to measure link or logic integrity without any shared seed.

## Interface
- `LOCK_COUNT`, default 4: consecutive correct predictions needed to declare lock (≥1).
- `LOSS_COUNT`, default 3: consecutive mispredictions in lock that drop lock (≥1).
- `ERR_W`, default 8: width of the saturating error counter (≥1).

- `clk_i` input 1: clock, all state updates on rising edge.
- `rst_ni` input 1: asynchronous active-low reset.
- `valid_i` input 1: `data_i` holds a sample this cycle.
- `data_i` input 4: received LFSR value.
- `clr_i` input 1: synchronous clear of `err_count_o` (and `sample_count_o` when compiled in).
- `locked_o` output 1: checker is in LOCKED.
- `err_pulse_o` output 1: one-cycle pulse per mismatch while locked.
- `err_count_o` output ERR_W: saturating mismatch count.

## Operation
- Internal state: FSM {HUNT, VERIFY, LOCKED}, `expect_q[3:0]`, match counter, miss counter.
- Cycles with `valid_i`=0 change nothing except `clr_i` effects; `err_pulse_o` is 0.
- HUNT: valid with `data_i`≠0 → `expect_q`←next(`data_i`), match cnt←0, go VERIFY. `data_i`=0 → stay HUNT.
- VERIFY, valid:
  - `data_i`==`expect_q` → `expect_q`←next(`data_i`), match cnt+1; when this is match number LOCK_COUNT go LOCKED, miss cnt←0.
  - mismatch, `data_i`≠0 → reseed: `expect_q`←next(`data_i`), match cnt←0, stay VERIFY.
  - mismatch, `data_i`=0 → HUNT.
- LOCKED, valid: `expect_q`←next(`expect_q`) always (flywheel; received data never reseeds).
  - match → miss cnt←0.
  - mismatch (including `data_i`=0) → `err_pulse_o`=1 next cycle, `err_count_o`+1 saturating at 2^ERR_W−1, miss cnt+1; on miss number LOSS_COUNT go HUNT.
- Errors are counted only in LOCKED; HUNT/VERIFY mismatches are silent.
- `clr_i` and an error increment in the same cycle: clear wins (count←0), pulse still asserted.

## Timing
- Reset values: FSM=HUNT, `expect_q`=0, counters=0, `locked_o`=0, `err_pulse_o`=0, `err_count_o`=0.
- Reset asserted mid-operation: all outputs go to reset values immediately, no clock needed; resync restarts from HUNT.
- All outputs registered. `locked_o` rises the cycle after the LOCK_COUNT-th matching sample is clocked in; falls the cycle after the LOSS_COUNT-th consecutive miss.
- `err_pulse_o` and `err_count_o` update the cycle after the offending sample.
- Minimum lock latency: LOCK_COUNT+1 valid samples. Back-to-back valid every cycle supported.

## Configuration
- `LFSR_CHECKER_STATS_EN` defined: adds output `sample_count_o` [ERR_W-1:0], saturating count of valid samples accepted while LOCKED; reset 0, cleared by `clr_i`, registered like `err_count_o`.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Lock: reset, feed 1010,0101,1011,0111,1111 back-to-back (LOCK_COUNT=4) → `locked_o`=1 the cycle after 1111, `err_count_o`=0.
- Flywheel error: locked, expected 1110 replaced by 0000, then 1100,1000 → one `err_pulse_o`, `err_count_o`=1, lock held, no further errors.
- Loss: locked, three consecutive wrong values (0000,0000,0000) with LOSS_COUNT=3 → `err_count_o`=3, `locked_o` falls after third; correct 5 samples → relock.
- Hunt/verify: feed 0000,0000 then 0110,0101 (mismatch),1011,0111,1111,1110 → no lock until 1110 clocked, `err_count_o` stays 0.
- Saturation and clear: ERR_W=2, alternate error/good samples for 5 errors → `err_count_o`=3; `clr_i` coincident with an error → count 0, pulse 1.
- Async reset mid-lock with clock stopped → `locked_o`,`err_count_o` 0 immediately; with `LFSR_CHECKER_STATS_EN`, 10 locked samples → `sample_count_o`=10.
